// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, funct3 codes, FSM states.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    // Load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access FSM states
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    // True when funct3 is a known width and the byte offset is naturally aligned for it.
    function automatic logic access_legal(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B, F3_BU: access_legal = 1'b1;
            F3_H, F3_HU: access_legal = ~off[0];
            F3_W:        access_legal = (off == 2'b00);
            default:     access_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts and extends the addressed byte/halfword/word from a 32-bit bus read.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rdata (bus word), addr_lo (byte offset), funct3 (width code), load_val (result).
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_val = rdata;
            F3_BU:   load_val = {24'd0, byte_sel};
            F3_HU:   load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: legality check, D-bus request/ack handshake, load alignment, MEM/WB register.
// Latency: cache hit completes in the issue cycle (result on WB_* next edge); ack after k BUSY cycles costs k stall cycles.
// Backpressure: mem_stall (combinational, depends on dbus_ack) freezes EX/MEM and upstream while an access is outstanding.
// Ports: MEM_* from EX/MEM; dbus_* request/ack bus to the D-cache; mem_stall, mem_err (registered pulse); WB_* registered MEM/WB outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    MEM_Mem_r,
    input  logic                    MEM_Mem_w,
    input  logic                    MEM_Reg_w,
    input  logic [1:0]              MEM_WB_sel,
    input  logic [DATA_WIDTH-1:0]   MEM_Imm,
    input  logic [DATA_WIDTH-1:0]   MEM_PC_Plus_4,
    input  logic [DATA_WIDTH-1:0]   MEM_ALU_Result,
    input  logic [DATA_WIDTH-1:0]   MEM_Mem_W_Data,
    input  logic [ADDR_WIDTH-1:0]   MEM_Rd_Addr,
    input  logic [DATA_WIDTH/8-1:0] MEM_Mem_W_Strb,
    input  logic [2:0]              MEM_Funct3,

    output logic                    dbus_req,
    output logic                    dbus_we,
    output logic [DATA_WIDTH-1:0]   dbus_addr,
    output logic [DATA_WIDTH-1:0]   dbus_wdata,
    output logic [DATA_WIDTH/8-1:0] dbus_wstrb,
    input  logic                    dbus_ack,
    input  logic [DATA_WIDTH-1:0]   dbus_rdata,

    output logic                    mem_stall,
    output logic                    mem_err,

    output logic                    WB_Reg_w,
    output logic [1:0]              WB_WB_sel,
    output logic [ADDR_WIDTH-1:0]   WB_Rd_Addr,
    output logic [DATA_WIDTH-1:0]   WB_Imm,
    output logic [DATA_WIDTH-1:0]   WB_PC_Plus_4,
    output logic [DATA_WIDTH-1:0]   WB_ALU_Result,
    output logic [DATA_WIDTH-1:0]   WB_Mem_Data
);

    localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            acc, legal, is_load, cnt_last;
    logic            done, timeout, err_now;
    logic [DATA_WIDTH-1:0] load_val;

    assign acc      = MEM_Mem_r | MEM_Mem_w;
    assign legal    = access_legal(MEM_Funct3, MEM_ALU_Result[1:0]);
    assign is_load  = MEM_Mem_r & ~MEM_Mem_w;
    assign cnt_last = (cnt_q == CNT_LAST);

    // Bus fields are pure functions of the (stall-frozen) EX/MEM inputs, so they
    // stay stable for the whole time the request is outstanding.
    assign dbus_we    = MEM_Mem_w;
    assign dbus_addr  = {MEM_ALU_Result[DATA_WIDTH-1:2], 2'b00};
    assign dbus_wstrb = MEM_Mem_w ? MEM_Mem_W_Strb : '0;

    always_comb begin
        case (MEM_Funct3[1:0])
            2'b00:   dbus_wdata = {4{MEM_Mem_W_Data[7:0]}};
            2'b01:   dbus_wdata = {2{MEM_Mem_W_Data[15:0]}};
            default: dbus_wdata = MEM_Mem_W_Data;
        endcase
    end

    // Request / stall / completion decode. An ack in the last allowed BUSY
    // cycle is still a success; only the absence of ack there is a timeout.
    always_comb begin
        dbus_req  = 1'b0;
        mem_stall = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        state_d   = state_q;
        if (state_q == ST_BUSY) begin
            dbus_req = 1'b1;
            if (dbus_ack) begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end else if (cnt_last) begin
                timeout = 1'b1;
                state_d = ST_IDLE;
            end else begin
                mem_stall = 1'b1;
            end
        end else if (acc && legal) begin
            dbus_req = 1'b1;
            if (dbus_ack) begin
                done = 1'b1;
            end else begin
                mem_stall = 1'b1;
                state_d   = ST_BUSY;
            end
        end
    end

    assign err_now = ((state_q == ST_IDLE) && acc && !legal) || timeout;

    // Wait counter is 0 on the first BUSY cycle and cleared whenever we leave BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BUSY && state_d == ST_BUSY)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    load_align u_load_align (
        .rdata    (dbus_rdata),
        .addr_lo  (MEM_ALU_Result[1:0]),
        .funct3   (MEM_Funct3),
        .load_val (load_val)
    );

    // MEM/WB register. During a stall only the write enable is squashed; the
    // data fields hold. Failed accesses (illegal, misaligned, timed out) retire
    // as bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err       <= 1'b0;
            WB_Reg_w      <= 1'b0;
            WB_WB_sel     <= '0;
            WB_Rd_Addr    <= '0;
            WB_Imm        <= '0;
            WB_PC_Plus_4  <= '0;
            WB_ALU_Result <= '0;
            WB_Mem_Data   <= '0;
        end else begin
            mem_err <= err_now;
            if (mem_stall) begin
                WB_Reg_w <= 1'b0;
            end else begin
                WB_Reg_w      <= MEM_Reg_w & ~err_now;
                WB_WB_sel     <= MEM_WB_sel;
                WB_Rd_Addr    <= MEM_Rd_Addr;
                WB_Imm        <= MEM_Imm;
                WB_PC_Plus_4  <= MEM_PC_Plus_4;
                WB_ALU_Result <= MEM_ALU_Result;
                WB_Mem_Data   <= (is_load && done) ? load_val : '0;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and runs loads and stores on the data bus (D-cache) through a request/acknowledge handshake. It drives `mem_stall`, which freezes the EX/MEM register and the upstream stages, and it aligns load data. It also owns the MEM/WB pipeline register that feeds write-back.

## Interface
- `DATA_WIDTH`, default 32: data and bus width; only 32 is supported.
- `ADDR_WIDTH`, default 5: register-file address width.
- `TIMEOUT`, default 64: maximum number of cycles an access may stay outstanding before it is aborted.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `MEM_Mem_r`, `MEM_Mem_w`, `MEM_Reg_w`  in  1 each  control bits from EX/MEM.
- `MEM_WB_sel`  in  2  write-back select, passed through.
- `MEM_Imm`, `MEM_PC_Plus_4`, `MEM_ALU_Result`, `MEM_Mem_W_Data`  in  32 each  `MEM_ALU_Result` is the byte address.
- `MEM_Rd_Addr`  in  `ADDR_WIDTH`  destination register.
- `MEM_Mem_W_Strb`  in  4  store byte strobes, already positioned.
- `MEM_Funct3`  in  3  load/store width code.
- `dbus_req`  out  1  access request.
- `dbus_we`  out  1  1 = store.
- `dbus_addr`  out  32  word-aligned address.
- `dbus_wdata`  out  32  replicated store data.
- `dbus_wstrb`  out  4  byte strobes.
- `dbus_ack`  in  1  access complete.
- `dbus_rdata`  in  32  read data, valid only while `dbus_ack` is high.
- `mem_stall`  out  1  freeze EX/MEM and upstream stages.
- `mem_err`  out  1  one-cycle pulse on misaligned, illegal or timed-out access.
- `WB_Reg_w`, `WB_WB_sel`, `WB_Rd_Addr`, `WB_Imm`, `WB_PC_Plus_4`, `WB_ALU_Result`, `WB_Mem_Data`  out  registered MEM/WB outputs.

## Operation
- An access is needed when `acc = MEM_Mem_r | MEM_Mem_w`. With both bits 0 the instruction is a bubble or non-memory op and passes straight to MEM/WB.
- Legality check, done before any request is issued:
  - funct3 000/100 (LB, LBU, SB): always aligned.
  - funct3 001/101 (LH, LHU, SH): needs `addr[0]=0`.
  - funct3 010 (LW, SW): needs `addr[1:0]=00`.
  - Any other funct3 is illegal.
  - A misaligned or illegal access raises no `dbus_req`, pulses `mem_err`, and writes a bubble into MEM/WB (`WB_Reg_w=0`) without stalling.
- FSM with two states, IDLE and BUSY:
  - IDLE, legal `acc`: assert `dbus_req`. If `dbus_ack` arrives the same cycle, the access completes with zero stall and the state stays IDLE. Otherwise assert `mem_stall` and go to BUSY.
  - BUSY: `dbus_req` and the other bus outputs stay held, stable from the EX/MEM inputs that are frozen by the stall. A wait counter increments each cycle.
    - On `dbus_ack`: `mem_stall=0`, result captured, go to IDLE.
    - When the counter reaches `TIMEOUT-1` without ack: drop the request, pulse `mem_err`, write a bubble, `mem_stall=0`, go to IDLE.
- Bus fields:
  - `dbus_addr = {addr[31:2],2'b00}`.
  - `dbus_we = MEM_Mem_w`.
  - `dbus_wstrb = MEM_Mem_W_Strb` for stores, 0 for loads.
  - `dbus_wdata`: SB gives the byte replicated x4, SH the halfword replicated x2, SW the word.
- Load alignment: select byte `addr[1:0]` or halfword `addr[1]` from `dbus_rdata`. LB and LH sign-extend; LBU and LHU zero-extend. The result goes to `WB_Mem_Data`. Stores and non-loads write 0 to `WB_Mem_Data`.
- MEM/WB register:
  - Loads every cycle `mem_stall=0`, including the completion cycle.
  - While `mem_stall=1`, it loads a bubble: `WB_Reg_w=0`, all other fields hold.
  - Fields not listed above pass through unchanged.

## Timing
- Reset (async) sends the FSM to IDLE and clears the counter. Every WB_* output resets to 0, as does `mem_err`. `dbus_req` and `mem_stall` are combinational and go to 0 once the upstream register is reset. Reset in BUSY abandons the access; the bus must tolerate request withdrawal.
- `dbus_req`, the bus fields and `mem_stall` are combinational from state and MEM_* inputs. `mem_stall` depends combinationally on `dbus_ack`; the D-cache must not make `dbus_ack` depend on `mem_stall`.
- Latency:
  - Cache hit (ack in the first cycle): one cycle, result visible on WB_* the next edge.
  - Ack after k cycles of BUSY: k stall cycles.
- `mem_err` is registered: it is high for the one cycle after the offending cycle.
- Timeout boundary: ack in the same cycle as the counter reaching `TIMEOUT-1` counts as success.

## Structure
- Shared package/header, already in use, provides `DATA_WIDTH`, `ADDR_WIDTH` and the funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101), plus a state enum for IDLE/BUSY.
- Sub-module `load_align`: purely combinational; takes `rdata`, `addr[1:0]` and `funct3`, returns the extended load value.

## Test plan
- LW at 0x100, ack in the same cycle, rdata=0xDEADBEEF: `mem_stall` never asserted; next cycle `WB_Mem_Data=0xDEADBEEF`, `WB_Reg_w=1`.
- LB at 0x103, ack after 3 cycles, rdata=0x80123456: `mem_stall` high for 3 cycles with WB bubbles (`WB_Reg_w=0`); then `WB_Mem_Data=0xFFFFFF80`. The same access as LBU gives `0x00000080`.
- SH at 0x202, data 0x0000ABCD, strobe 1100: `dbus_addr=0x200`, `dbus_wdata=0xABCDABCD`, `dbus_we=1`.
- LW at 0x101: no `dbus_req`, `mem_err` pulses once, `WB_Reg_w=0`, no stall.
- Load with ack never returned and `TIMEOUT=8`: stall for exactly 8 cycles, then `mem_err` pulses, the request drops, and the FSM returns to IDLE.
- Reset asserted in BUSY: `dbus_req`, `mem_stall` and all WB_* go to 0 immediately, and the next legal access proceeds normally.
